// File: rtl/button_event_scheduler.sv
// Multi-button debounce front end: shared sample tick, per-button press-edge capture,
// round-robin serialization of presses into a small event FIFO drained over valid/ready.
module button_event_scheduler #(
   parameter int NUM_BUTTONS = 4,
   parameter int TICK_DIV    = 2000000,
   parameter int FIFO_DEPTH  = 4,
   parameter int IDX_W       = 2
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   enable,
   input  logic [NUM_BUTTONS-1:0] buttons,
   output logic                   eventValid,
   output logic [IDX_W-1:0]       eventIndex,
   input  logic                   eventReady,
   output logic [NUM_BUTTONS-1:0] pressLevel,
   output logic                   overflow,
   input  logic                   clearOverflow
);

   localparam int TCW = $clog2(TICK_DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   logic [NUM_BUTTONS-1:0] syncA, syncB;
   logic [NUM_BUTTONS-1:0] q1;
   logic [NUM_BUTTONS-1:0] pending;
   logic [NUM_BUTTONS-1:0] newEdge;
   logic [NUM_BUTTONS-1:0] grantMask;
   logic [TCW-1:0]         tickCount;
   logic                   tick;
   logic                   grantValid;
   logic [IDX_W-1:0]       grantIdx;
   logic [IDX_W-1:0]       rrPtr;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic                   ovfSet;
   logic [IDX_W-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]          wrPtr, rdPtr;
   logic [CW-1:0]          count;

   // Synchronizer stage: free-running, independent of enable
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= buttons;
         syncB <= syncA;
      end
   end

   assign tick = enable && (tickCount == TCW'(TICK_DIV - 1));

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         tickCount <= '0;
      end else if (!enable || tick) begin
         tickCount <= '0;
      end else begin
         tickCount <= tickCount + 1'b1;
      end
   end

   // Debounce stage: level and press edge both sampled on the tick
   assign newEdge = tick ? (syncB & ~q1) : '0;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         q1 <= '0;
      end else if (tick) begin
         q1 <= syncB;
      end
   end

   always_comb begin
      int idx;
      idx        = 0;
      grantValid = 1'b0;
      grantIdx   = '0;
      if (!full) begin
         for (int k = 0; k < NUM_BUTTONS; k++) begin
            idx = (int'(rrPtr) + k) % NUM_BUTTONS;
            if (!grantValid && (|(pending & (NUM_BUTTONS'(1) << idx)))) begin
               grantValid = 1'b1;
               grantIdx   = IDX_W'(idx);
            end
         end
      end
   end

   assign grantMask = grantValid ? (NUM_BUTTONS'(1) << grantIdx) : '0;
   // A fresh edge on a still-waiting button has nowhere to go
   assign ovfSet    = |(newEdge & pending & ~grantMask);

   // Arbitration stage: pending set beats same-cycle grant clear
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         pending  <= '0;
         rrPtr    <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~grantMask) | newEdge;
         if (grantValid) begin
            rrPtr <= (int'(grantIdx) == NUM_BUTTONS - 1) ? '0 : grantIdx + 1'b1;
         end
         if (ovfSet) begin
            overflow <= 1'b1;
         end else if (clearOverflow) begin
            overflow <= 1'b0;
         end
      end
   end

   assign full = (count == CW'(FIFO_DEPTH));
   assign push = grantValid;
   assign pop  = eventValid && eventReady;

   // FIFO stage: full comes from the registered count, so a pop never frees a slot early
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wrPtr] <= grantIdx;
   end

   assign eventValid = (count != '0);
   assign eventIndex = eventValid ? mem[rdPtr] : '0;
   assign pressLevel = q1;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: lockstep comparison against a queue-based
// behavioural model plus directed scenario checks on event order and timing.
module tb_button_event_scheduler;

   localparam int NB    = 4;
   localparam int TDIV  = 4;
   localparam int DEPTH = 4;
   localparam int IW    = 2;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic          enable = 1'b0;
   logic [NB-1:0] buttons = '0;
   logic          eventReady = 1'b0;
   logic          clearOverflow = 1'b0;
   logic          eventValid;
   logic [IW-1:0] eventIndex;
   logic [NB-1:0] pressLevel;
   logic          overflow;
   logic [7:0]    dutVec;

   int total = 0;
   int bad   = 0;
   int got[$];

   // reference model state
   int            mTick = 0;
   logic [NB-1:0] mS1 = '0, mS2 = '0, mLvl = '0, mPend = '0;
   int            mRr = 0;
   int            mQ[$];
   logic          mOvf = 1'b0;

   button_event_scheduler #(
      .NUM_BUTTONS(NB), .TICK_DIV(TDIV), .FIFO_DEPTH(DEPTH), .IDX_W(IW)
   ) dut (
      .clock(clock), .resetN(resetN), .enable(enable), .buttons(buttons),
      .eventValid(eventValid), .eventIndex(eventIndex), .eventReady(eventReady),
      .pressLevel(pressLevel), .overflow(overflow), .clearOverflow(clearOverflow)
   );

   always #5 clock = ~clock;

   assign dutVec = {eventValid, eventIndex, pressLevel, overflow};

   always @(posedge clock or negedge resetN) begin : model
      int            g;
      logic [NB-1:0] np;
      logic          t, ovf, popping;
      if (!resetN) begin
         mTick = 0; mS1 = '0; mS2 = '0; mLvl = '0; mPend = '0;
         mRr = 0; mQ.delete(); mOvf = 1'b0;
      end else begin
         t = enable && (mTick == TDIV - 1);
         g = -1;
         if (mPend != '0 && mQ.size() < DEPTH)
            for (int k = 0; k < NB; k++)
               if (g < 0 && mPend[(mRr + k) % NB]) g = (mRr + k) % NB;
         popping = (mQ.size() > 0) && eventReady;
         np = mPend;
         if (g >= 0) np[g] = 1'b0;
         ovf = 1'b0;
         if (t)
            for (int i = 0; i < NB; i++)
               if (mS2[i] && !mLvl[i]) begin
                  if (np[i]) ovf = 1'b1;
                  np[i] = 1'b1;
               end
         if (popping) void'(mQ.pop_front());
         if (g >= 0) begin
            mQ.push_back(g);
            mRr = (g + 1) % NB;
         end
         mPend = np;
         if (ovf) mOvf = 1'b1;
         else if (clearOverflow) mOvf = 1'b0;
         if (t) mLvl = mS2;
         mS2 = mS1;
         mS1 = buttons;
         mTick = (!enable || t) ? 0 : mTick + 1;
      end
   end

   function automatic logic [7:0] model_vec();
      logic          v;
      logic [IW-1:0] h;
      v = (mQ.size() > 0);
      h = v ? IW'(mQ[0]) : '0;
      return {v, h, mLvl, mOvf};
   endfunction

   // Advances to the next falling edge, logging any event the DUT hands over on the way.
   task automatic step();
      logic p;
      int   idx;
      p   = eventValid && eventReady;
      idx = int'(eventIndex);
      @(negedge clock);
      if (p) got.push_back(idx);
   endtask

   task automatic reset_pulse();
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      step();
   endtask

   task automatic test_reset();
      resetN = 1'b0; buttons = 4'hF; enable = 1'b1;
      repeat (3) step();
      total++;
      if (dutVec !== 8'h00) begin bad++; $display("FAIL reset_state: got=%h want=00", dutVec); end
      resetN = 1'b1; buttons = '0;
      repeat (12) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL reset_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
   endtask

   task automatic test_single_press();
      int lvlAt, vldAt;
      lvlAt = -1; vldAt = -1;
      got.delete(); eventReady = 1'b1; buttons = 4'b0001;
      for (int c = 0; c < 16; c++) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL single_lock: dut=%h model=%h", dutVec, model_vec()); end
         if (lvlAt < 0 && pressLevel[0]) lvlAt = c;
         if (vldAt < 0 && eventValid) vldAt = c;
      end
      total++;
      if (vldAt - lvlAt != 1 || lvlAt < 0) begin bad++; $display("FAIL single_latency: level_at=%0d valid_at=%0d want gap 1", lvlAt, vldAt); end
      total++;
      if (got.size() != 1 || got[0] != 0) begin bad++; $display("FAIL single_event: count=%0d want 1 of index 0", got.size()); end
      buttons = '0;
      repeat (12) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL release_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      total++;
      if (got.size() != 1) begin bad++; $display("FAIL release_event: count=%0d want 1", got.size()); end
   endtask

   task automatic test_bounce();
      logic b;
      int   w;
      got.delete(); buttons = '0; eventReady = 1'b1;
      w = 0;
      while (mTick != 0 && w < 8) begin step(); w++; end
      total++;
      if (mTick != 0) begin bad++; $display("FAIL bounce_align: tick phase=%0d want 0", mTick); end
      b = 1'($urandom_range(0, 1));
      for (int c = 0; c < 3; c++) begin
         buttons[2] = b; b = ~b;
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL bounce_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      buttons[2] = 1'b1;
      repeat (16) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL bounce_hold: dut=%h model=%h", dutVec, model_vec()); end
      end
      total++;
      if (got.size() != 1 || got[0] != 2) begin bad++; $display("FAIL bounce_event: count=%0d want 1 of index 2", got.size()); end
      total++;
      if (pressLevel[2] !== 1'b1) begin bad++; $display("FAIL bounce_level: got=%b want 1", pressLevel[2]); end
   endtask

   task automatic test_simultaneous();
      logic [5:0] ord;
      buttons = '0; eventReady = 1'b1;
      reset_pulse();
      got.delete(); buttons = 4'b1011;
      repeat (16) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL simul_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      ord = (got.size() == 3) ? {2'(got[0]), 2'(got[1]), 2'(got[2])} : 6'h3F;
      total++;
      if (ord !== {2'd0, 2'd1, 2'd3}) begin bad++; $display("FAIL simul_order_rr0: got=%b want 000111", ord); end
      buttons = '0;       repeat (12) step();
      buttons = 4'b0010;  repeat (12) step();
      buttons = '0;       repeat (12) step();
      got.delete(); buttons = 4'b1011;
      repeat (16) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL simul2_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      ord = (got.size() == 3) ? {2'(got[0]), 2'(got[1]), 2'(got[2])} : 6'h3F;
      total++;
      if (ord !== {2'd3, 2'd0, 2'd1}) begin bad++; $display("FAIL simul_order_rr2: got=%b want 110001", ord); end
      buttons = '0; repeat (12) step();
   endtask

   task automatic test_backpressure();
      logic [NB-1:0] masks [5];
      masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      eventReady = 1'b0;
      reset_pulse();
      got.delete();
      for (int p = 0; p < 5; p++) begin
         buttons = masks[p];
         repeat (8) begin
            step(); total++;
            if (dutVec !== model_vec()) begin bad++; $display("FAIL bp_lock: dut=%h model=%h", dutVec, model_vec()); end
         end
         buttons = '0;
         repeat (8) step();
      end
      total++;
      if ({eventValid, eventIndex, overflow} !== {1'b1, 2'd0, 1'b0}) begin
         bad++; $display("FAIL bp_queued: valid/idx/ovf=%b%b%b want 1000", eventValid, eventIndex, overflow);
      end
      buttons = 4'b0001;
      repeat (8) step();
      buttons = '0;
      repeat (2) step();
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow_set: got=%b want 1", overflow); end
      clearOverflow = 1'b1; step();
      clearOverflow = 1'b0; step();
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow_clear: got=%b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [9:0] ord;
      eventReady = 1'b1; step();
      eventReady = 1'b0;
      total++;
      if ({eventValid, eventIndex} !== {1'b1, 2'd1}) begin bad++; $display("FAIL fpp_head: got=%b%b want 101", eventValid, eventIndex); end
      repeat (3) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL fpp_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      eventReady = 1'b1;
      repeat (10) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL drain_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      ord = (got.size() == 5) ? {2'(got[0]), 2'(got[1]), 2'(got[2]), 2'(got[3]), 2'(got[4])} : 10'h3FF;
      total++;
      if (ord !== {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}) begin bad++; $display("FAIL drain_order: got=%b want 0001101100", ord); end
   endtask

   task automatic test_enable_reset();
      int w;
      enable = 1'b0; eventReady = 1'b1; got.delete();
      buttons = NB'($urandom_range(1, 15));
      repeat (20) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL disable_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      total++;
      if (got.size() != 0) begin bad++; $display("FAIL disable_events: count=%0d want 0", got.size()); end
      buttons = '0; enable = 1'b1; repeat (10) step();
      eventReady = 1'b0; buttons = 4'b0100;
      w = 0;
      while (!eventValid && w < 20) begin step(); w++; end
      total++;
      if (!eventValid) begin bad++; $display("FAIL queue_wait: valid=%b want 1 within 20 cycles", eventValid); end
      #2 resetN = 1'b0;
      #1;
      total++;
      if (dutVec !== 8'h00) begin bad++; $display("FAIL async_reset: got=%h want 00", dutVec); end
      step();
      resetN = 1'b1; eventReady = 1'b1; got.delete();
      repeat (16) begin
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL post_reset_lock: dut=%h model=%h", dutVec, model_vec()); end
      end
      total++;
      if (got.size() != 1 || got[0] != 2) begin bad++; $display("FAIL post_reset_event: count=%0d want 1 of index 2", got.size()); end
      buttons = '0; repeat (8) step();
   endtask

   task automatic test_random();
      reset_pulse();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0) buttons = NB'($urandom);
         eventReady    = ($urandom_range(0, 3) != 0);
         clearOverflow = ($urandom_range(0, 15) == 0);
         enable        = ($urandom_range(0, 31) != 0);
         step(); total++;
         if (dutVec !== model_vec()) begin bad++; $display("FAIL random_lock: cyc=%0d dut=%h model=%h", c, dutVec, model_vec()); end
      end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_backpressure();
      test_full_push_pop();
      test_enable_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
